axis_skew: RTL

Input skew stage for the systolic array. Accepts one R-lane AXI-stream beat per cycle and emits it as a diagonal wavefront, so that lane r reaches the array r cycles after lane 0. After the beat carrying `s_last`, it self-drains with bubble beats so that the final wavefront fully exits. It replaces hand-instantiated per-row delay chains and drives the array's row inputs directly.

---
 rtl/axis_skew.sv | 120 ++++++++++++
 1 files changed

// File: rtl/axis_skew.sv
// Input skew stage: turns one R-lane stream beat per cycle into a diagonal wavefront
// (lane r delayed r+1 advances) and self-drains after s_last. Option: SKEW_ZERO_FILL_EN.
module axis_skew #(
    parameter int R = 4,
    parameter int W = 8
) (
    input  logic                c,
    input  logic                rng,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [R-1:0][W-1:0] s_data,
    input  logic                s_last,
    input  logic                m_ready,
    output logic [R-1:0][W-1:0] m_data,
    output logic [R-1:0]        m_valid,
    output logic [R-1:0]        m_last,
    output logic                busy,
    output logic [1:0]          fsm_state
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] DLAST = CW'((R > 1) ? (R - 2) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] dcnt;
    logic          accept;
    logic          adv;

    // Handshake: a beat transfers when s_valid & s_ready. s_ready never looks at s_valid,
    // and the whole wavefront moves only on adv, so a stalled array freezes every lane.
    assign s_ready   = m_ready & (state != DRAIN);
    assign accept    = s_valid & s_ready;
    assign adv       = m_ready & ((state == DRAIN) | accept);
    assign fsm_state = state;

    always_ff @(posedge c or negedge rng) begin
        if (!rng) begin
            state <= IDLE;
            dcnt  <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        if (s_last) begin
                            if (R > 1) begin
                                state <= DRAIN;
                                dcnt  <= '0;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // R-1 bubble advances push the final beat out of the longest lane.
                    if (adv) begin
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == DLAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < R; r++) begin : g_lane
        logic [W-1:0] d_q [0:r];
        logic         v_q [0:r];
        logic         l_q [0:r];
        logic [W-1:0] fill;

`ifdef SKEW_ZERO_FILL_EN
        assign fill = accept ? s_data[r] : '0;
`else
        assign fill = s_data[r];
`endif

        always_ff @(posedge c or negedge rng) begin
            if (!rng) begin
                for (int i = 0; i <= r; i++) begin
                    d_q[i] <= '0;
                    v_q[i] <= 1'b0;
                    l_q[i] <= 1'b0;
                end
            end else if (adv) begin
                d_q[0] <= fill;
                v_q[0] <= accept;
                l_q[0] <= accept & s_last;
                for (int i = 1; i <= r; i++) begin
                    d_q[i] <= d_q[i-1];
                    v_q[i] <= v_q[i-1];
                    l_q[i] <= l_q[i-1];
                end
            end
        end

        assign m_data[r]  = d_q[r];
        assign m_valid[r] = v_q[r];
        assign m_last[r]  = l_q[r];
    end

endmodule
